// File: rtl/pc_gen.sv
// pc_gen: IF-stage program-counter generator.
// Holds the fetch PC, applies trap / EX redirects, and predicts taken
// branches through a direct-mapped BTB with 2-bit saturating counters.
module pc_gen #(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
  parameter int unsigned        BTB_IDX_W = 4,
  parameter bit                 USE_BTB   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_stall,
  input  logic              trap_en,
  input  logic [ADDR_W-1:0] trap_vec,
  input  logic              ex_redirect,
  input  logic [ADDR_W-1:0] ex_redirect_pc,
  input  logic              ex_upd_en,
  input  logic [ADDR_W-1:0] ex_upd_pc,
  input  logic [ADDR_W-1:0] ex_upd_target,
  input  logic              ex_upd_taken,
  output logic [ADDR_W-1:0] if_pc_i,
  output logic [ADDR_W-1:0] if_npc_i,
  output logic              if_pred_taken,
  output logic              pc_valid
);

  localparam int unsigned TAG_W = ADDR_W - BTB_IDX_W - 2;
  localparam int unsigned DEPTH = 1 << BTB_IDX_W;

  logic [ADDR_W-1:0] r_pc;
  logic              r_valid;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_pred_tgt;
  logic              w_pred_taken;
  logic [ADDR_W-1:0] w_npc;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_pc_load;

  assign w_pc_plus4 = r_pc + ADDR_W'(4);

  if (USE_BTB) begin : g_btb
    logic              r_btb_vld [DEPTH];
    logic [TAG_W-1:0]  r_btb_tag [DEPTH];
    logic [ADDR_W-1:0] r_btb_tgt [DEPTH];
    logic [1:0]        r_btb_ctr [DEPTH];

    logic [BTB_IDX_W-1:0] w_rd_idx;
    logic [TAG_W-1:0]     w_rd_tag;
    logic                 w_rd_hit;
    logic [BTB_IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0]     w_upd_tag;
    logic                 w_upd_hit;
    logic                 w_unused_upd_lsb;

    assign w_rd_idx  = r_pc[BTB_IDX_W+1:2];
    assign w_rd_tag  = r_pc[ADDR_W-1:BTB_IDX_W+2];
    assign w_upd_idx = ex_upd_pc[BTB_IDX_W+1:2];
    assign w_upd_tag = ex_upd_pc[ADDR_W-1:BTB_IDX_W+2];
    assign w_unused_upd_lsb = ^ex_upd_pc[1:0];

    // Lookup for the current fetch PC; reads see pre-update contents.
    always_comb begin
      w_rd_hit     = r_btb_vld[w_rd_idx] && (r_btb_tag[w_rd_idx] == w_rd_tag);
      w_upd_hit    = r_btb_vld[w_upd_idx] && (r_btb_tag[w_upd_idx] == w_upd_tag);
      w_pred_taken = w_rd_hit && r_btb_ctr[w_rd_idx][1];
      w_pred_tgt   = r_btb_tgt[w_rd_idx];
    end

    // BTB training from resolved branches in EX, independent of stall/redirect.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          r_btb_vld[i] <= 1'b0;
          r_btb_tag[i] <= '0;
          r_btb_tgt[i] <= '0;
          r_btb_ctr[i] <= 2'b01;
        end
      end else if (ex_upd_en) begin
        if (w_upd_hit) begin
          if (ex_upd_taken) begin
            r_btb_tgt[w_upd_idx] <= ex_upd_target;
            if (r_btb_ctr[w_upd_idx] != 2'b11)
              r_btb_ctr[w_upd_idx] <= r_btb_ctr[w_upd_idx] + 2'd1;
          end else if (r_btb_ctr[w_upd_idx] != 2'b00) begin
            r_btb_ctr[w_upd_idx] <= r_btb_ctr[w_upd_idx] - 2'd1;
          end
        end else if (ex_upd_taken) begin
          r_btb_vld[w_upd_idx] <= 1'b1;
          r_btb_tag[w_upd_idx] <= w_upd_tag;
          r_btb_tgt[w_upd_idx] <= ex_upd_target;
          r_btb_ctr[w_upd_idx] <= 2'b10;
        end
      end
    end
  end else begin : g_no_btb
    logic w_unused_upd;

    assign w_unused_upd = ^{ex_upd_en, ex_upd_pc, ex_upd_target, ex_upd_taken};
    assign w_pred_taken = 1'b0;
    assign w_pred_tgt   = '0;
  end

  assign w_npc         = w_pred_taken ? w_pred_tgt : w_pc_plus4;
  assign if_npc_i      = w_npc;
  assign if_pred_taken = w_pred_taken;
  assign if_pc_i       = r_pc;
  assign pc_valid      = r_valid;

  // Next-PC select: trap > EX redirect > stall hold > prediction.
  // Before pc_valid is set only redirects move the PC, so RESET_VEC is fetched first.
  always_comb begin
    w_pc_next = w_npc;
    w_pc_load = 1'b0;
    if (trap_en) begin
      w_pc_next = trap_vec;
      w_pc_load = 1'b1;
    end else if (ex_redirect) begin
      w_pc_next = ex_redirect_pc;
      w_pc_load = 1'b1;
    end else if (r_valid && !if_stall) begin
      w_pc_next = w_npc;
      w_pc_load = 1'b1;
    end
  end

  // Fetch PC register; every loaded target is forced word aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= RESET_VEC;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b1;
      if (w_pc_load)
        r_pc <= {w_pc_next[ADDR_W-1:2], 2'b00};
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen (default parameters).
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        if_stall;
  logic        trap_en;
  logic [31:0] trap_vec;
  logic        ex_redirect;
  logic [31:0] ex_redirect_pc;
  logic        ex_upd_en;
  logic [31:0] ex_upd_pc;
  logic [31:0] ex_upd_target;
  logic        ex_upd_taken;
  logic [31:0] if_pc_i;
  logic [31:0] if_npc_i;
  logic        if_pred_taken;
  logic        pc_valid;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  pc_gen #(
    .ADDR_W    (32),
    .RESET_VEC (32'h0000_0000),
    .BTB_IDX_W (4),
    .USE_BTB   (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_stall       (if_stall),
    .trap_en        (trap_en),
    .trap_vec       (trap_vec),
    .ex_redirect    (ex_redirect),
    .ex_redirect_pc (ex_redirect_pc),
    .ex_upd_en      (ex_upd_en),
    .ex_upd_pc      (ex_upd_pc),
    .ex_upd_target  (ex_upd_target),
    .ex_upd_taken   (ex_upd_taken),
    .if_pc_i        (if_pc_i),
    .if_npc_i       (if_npc_i),
    .if_pred_taken  (if_pred_taken),
    .pc_valid       (pc_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One rising edge, then return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
    ex_upd_en     = 1'b1;
    ex_upd_pc     = pc;
    ex_upd_target = tgt;
    ex_upd_taken  = taken;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    ex_redirect    = 1'b1;
    ex_redirect_pc = pc;
    tick();
    ex_redirect    = 1'b0;
  endtask

  task automatic chk_pred(input string tag, input logic taken, input logic [31:0] npc);
    check({tag, "_taken"}, {31'd0, if_pred_taken}, {31'd0, taken});
    check({tag, "_npc"}, if_npc_i, npc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; if_stall = 1'b0; trap_en = 1'b0; trap_vec = '0;
    ex_redirect = 1'b0; ex_redirect_pc = '0;
    ex_upd_en = 1'b0; ex_upd_pc = '0; ex_upd_target = '0; ex_upd_taken = 1'b0;

    // 1: reset and sequential fetch
    #2;
    check("rst_pc", if_pc_i, 32'h0);
    check("rst_valid", {31'd0, pc_valid}, 32'd0);
    @(negedge clk);
    check("rst_hold_valid", {31'd0, pc_valid}, 32'd0);
    rst = 1'b1;
    tick();
    check("first_pc", if_pc_i, 32'h0);
    check("first_valid", {31'd0, pc_valid}, 32'd1);
    tick(); check("seq_4", if_pc_i, 32'h4);
    tick(); check("seq_8", if_pc_i, 32'h8);
    tick(); check("seq_c", if_pc_i, 32'hC);
    tick(); check("seq_10", if_pc_i, 32'h10);

    // 2: stall, then redirect while stalled (low bits dropped)
    if_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", if_pc_i, 32'h10);
    end
    redirect_to(32'h203);
    check("redir_stall", if_pc_i, 32'h200);
    if_stall = 1'b0;

    // 3: trap beats redirect
    trap_en = 1'b1; trap_vec = 32'h80;
    ex_redirect = 1'b1; ex_redirect_pc = 32'h400;
    tick();
    trap_en = 1'b0; ex_redirect = 1'b0;
    check("trap_prio", if_pc_i, 32'h80);

    // 4: BTB allocate, predict, alias, counter saturation
    if_stall = 1'b1;
    upd(32'h20, 32'h100, 1'b1);
    tick();
    ex_upd_en = 1'b0;
    check("upd_stall_hold", if_pc_i, 32'h80);
    redirect_to(32'h14);
    if_stall = 1'b0;
    chk_pred("pre_14", 1'b0, 32'h18);
    tick(); tick(); tick();
    check("reach_20", if_pc_i, 32'h20);
    chk_pred("alloc_20", 1'b1, 32'h100);
    tick(); check("follow_pred", if_pc_i, 32'h100);
    tick(); check("after_tgt", if_pc_i, 32'h104);

    if_stall = 1'b1;
    redirect_to(32'h60);
    chk_pred("alias_60", 1'b0, 32'h64);
    upd(32'h60, 32'h300, 1'b0);
    tick();
    ex_upd_en = 1'b0;
    chk_pred("miss_nt_60", 1'b0, 32'h64);
    redirect_to(32'h20);
    chk_pred("intact_20", 1'b1, 32'h100);

    upd(32'h20, 32'h999, 1'b0);
    chk_pred("same_cyc_old", 1'b1, 32'h100);
    tick(); chk_pred("ctr01", 1'b0, 32'h24);
    tick(); tick();
    upd(32'h20, 32'h140, 1'b1);
    tick(); chk_pred("sat00_inc", 1'b0, 32'h24);
    tick(); chk_pred("ctr10_newtgt", 1'b1, 32'h140);
    tick(); tick();
    upd(32'h20, 32'h999, 1'b0);
    tick(); chk_pred("sat11_dec", 1'b1, 32'h140);
    tick(); chk_pred("dec_to_01", 1'b0, 32'h24);
    upd(32'h20, 32'h100, 1'b1);
    tick();
    ex_upd_en = 1'b0;
    chk_pred("retrain", 1'b1, 32'h100);
    if_stall = 1'b0;

    // 5: wrap at top of address space
    redirect_to(32'hFFFF_FFFC);
    check("top_pc", if_pc_i, 32'hFFFF_FFFC);
    check("top_npc", if_npc_i, 32'h0);
    tick(); check("wrap_pc", if_pc_i, 32'h0);

    // 6: async reset mid-run discards pending redirect/update
    redirect_to(32'h20);
    chk_pred("pre_rst_20", 1'b1, 32'h100);
    ex_redirect = 1'b1; ex_redirect_pc = 32'h400;
    upd(32'h60, 32'h500, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_pc", if_pc_i, 32'h0);
    check("async_rst_valid", {31'd0, pc_valid}, 32'd0);
    @(negedge clk);
    ex_redirect = 1'b0; ex_upd_en = 1'b0;
    check("rst_low_pc", if_pc_i, 32'h0);
    rst = 1'b1;
    tick();
    check("rerel_pc", if_pc_i, 32'h0);
    check("rerel_valid", {31'd0, pc_valid}, 32'd1);
    redirect_to(32'h20);
    chk_pred("post_rst_20", 1'b0, 32'h24);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
